// File: rtl/divider_if.sv
// Operand/result bundle for the sequential signed divider.
// The master side issues start/a/b; the slave side returns results and status.
interface divider_if;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] quot;
  logic [63:0] rem;
  logic        busy;
  logic        done;
  logic        div0;
  logic        ovf;

  modport master (
    output start, a, b,
    input  quot, rem, busy, done, div0, ovf
  );

  modport slave (
    input  start, a, b,
    output quot, rem, busy, done, div0, ovf
  );
endinterface

// File: rtl/divider.sv
// 64-bit signed radix-2 restoring divider: 64 CALC cycles plus one FIX cycle,
// with a one-cycle fast path for divide-by-zero and the MIN/-1 overflow case.
module divider (
  input  logic      clk,
  input  logic      rst_n,
  divider_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam logic [63:0] MIN_INT = {1'b1, 63'd0};

  state_t r_state;
  state_t w_next;

  logic        r_sign_a;
  logic        r_sign_b;
  logic        r_div0_p;
  logic        r_ovf_p;
  logic [63:0] r_dvd;
  logic [63:0] r_dvs;
  logic [64:0] r_prem;
  logic [5:0]  r_cnt;

  logic [63:0] r_quot;
  logic [63:0] r_rem;
  logic        r_busy;
  logic        r_done;
  logic        r_div0;
  logic        r_ovf;

  logic        w_accept;
  logic        w_is_div0;
  logic        w_is_ovf;
  logic [63:0] w_abs_a;
  logic [63:0] w_abs_b;
  logic [65:0] w_shift;
  logic [65:0] w_diff;
  logic [63:0] w_quot_fix;
  logic [63:0] w_rem_fix;

  assign w_accept  = (r_state == IDLE) && bus.start;
  assign w_is_div0 = (bus.b == '0);
  assign w_is_ovf  = (bus.a == MIN_INT) && (bus.b == '1);
  assign w_abs_a   = bus.a[63] ? -bus.a : bus.a;
  assign w_abs_b   = bus.b[63] ? -bus.b : bus.b;

  // The partial remainder never exceeds 2^64, so bit 65 of the trial
  // difference is a reliable borrow (negative-result) indicator.
  assign w_shift = {r_prem, r_dvd[63]};
  assign w_diff  = w_shift - {2'b00, r_dvs};

  always_comb begin
    w_quot_fix = r_dvd;
    w_rem_fix  = r_prem[63:0];
    if (r_div0_p) begin
      w_quot_fix = '1;
      w_rem_fix  = r_sign_a ? -r_dvd : r_dvd;
    end else if (r_ovf_p) begin
      w_quot_fix = MIN_INT;
      w_rem_fix  = '0;
    end else begin
      if (r_sign_a ^ r_sign_b) w_quot_fix = -r_dvd;
      if (r_sign_a)            w_rem_fix  = -r_prem[63:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (w_is_div0 || w_is_ovf) w_next = FIX;
          else                       w_next = CALC;
        end
      end
      CALC:    if (r_cnt == 6'd63) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_div0_p <= 1'b0;
      r_ovf_p  <= 1'b0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_prem   <= '0;
      r_cnt    <= '0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sign_a <= bus.a[63];
            r_sign_b <= bus.b[63];
            r_dvd    <= w_abs_a;
            r_dvs    <= w_abs_b;
            r_prem   <= '0;
            r_cnt    <= '0;
            r_div0_p <= w_is_div0;
            r_ovf_p  <= w_is_ovf && !w_is_div0;
            r_busy   <= 1'b1;
          end
        end
        CALC: begin
          if (!w_diff[65]) begin
            r_prem <= w_diff[64:0];
            r_dvd  <= {r_dvd[62:0], 1'b1};
          end else begin
            r_prem <= w_shift[64:0];
            r_dvd  <= {r_dvd[62:0], 1'b0};
          end
          r_cnt <= r_cnt + 6'd1;
        end
        FIX: begin
          r_quot <= w_quot_fix;
          r_rem  <= w_rem_fix;
          r_div0 <= r_div0_p;
          r_ovf  <= r_ovf_p;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign bus.quot = r_quot;
  assign bus.rem  = r_rem;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.div0 = r_div0;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed vector table, multi-cycle corner
// sequences, and back-to-back random operations against a behavioural model.
module tb_divider;

  logic clk;
  logic rst_n;
  divider_if bus ();

  divider dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  localparam logic [63:0] MIN_V = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MAX_V = 64'h7FFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    logic        d0;
    logic        ov;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mag(input logic [63:0] x);
    return x[63] ? -x : x;
  endfunction

  // Behavioural reference: language-level truncating division and modulus.
  task automatic ref_div(input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] q, output logic [63:0] r,
                         output logic d0, output logic ov);
    longint sx;
    longint sy;
    sx = x;
    sy = y;
    d0 = 1'b0;
    ov = 1'b0;
    if (y == 64'd0) begin
      q  = 64'hFFFF_FFFF_FFFF_FFFF;
      r  = x;
      d0 = 1'b1;
    end else if (x == MIN_V && y == 64'hFFFF_FFFF_FFFF_FFFF) begin
      q  = MIN_V;
      r  = 64'd0;
      ov = 1'b1;
    end else begin
      q = sx / sy;
      r = sx % sy;
    end
  endtask

  task automatic do_op(input logic [63:0] ta, input logic [63:0] tb_v,
                       output logic [63:0] q, output logic [63:0] r,
                       output logic d0, output logic ov,
                       output int lat, output int busy_cnt, output logic busy_at_done);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_v;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = {$urandom, $urandom};
    bus.b     = {$urandom, $urandom};
    lat      = 0;
    busy_cnt = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) busy_cnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    q            = bus.quot;
    r            = bus.rem;
    d0           = bus.div0;
    ov           = bus.ovf;
    busy_at_done = bus.busy;
  endtask

  task automatic rand_operand(output logic [63:0] x);
    int unsigned k;
    k = $urandom_range(0, 11);
    case (k)
      0:       x = MIN_V;
      1:       x = MAX_V;
      2:       x = 64'd1;
      3:       x = 64'hFFFF_FFFF_FFFF_FFFF;
      4:       x = 64'd0;
      5:       x = 64'($signed($urandom_range(0, 200)) - 100);
      6:       x = {32'd0, $urandom};
      default: x = {$urandom, $urandom};
    endcase
  endtask

  initial begin
    logic [63:0] q, r, eq, er;
    logic        d0, ov, ed0, eov, bad;
    logic        busy_at_done;
    int          lat, busy_cnt, exp_lat, ndone, dcyc;
    logic [63:0] prev_q;
    longint      inv;

    checks   = 0;
    failures = 0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b0;

    vecs[0]  = '{64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 1'b0};
    vecs[1]  = '{-64'sd100, 64'd7, -64'sd14, -64'sd2, 1'b0, 1'b0};
    vecs[2]  = '{64'd100, -64'sd7, -64'sd14, 64'd2, 1'b0, 1'b0};
    vecs[3]  = '{-64'sd100, -64'sd7, 64'd14, -64'sd2, 1'b0, 1'b0};
    vecs[4]  = '{64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd100, 1'b1, 1'b0};
    vecs[5]  = '{MIN_V, 64'hFFFF_FFFF_FFFF_FFFF, MIN_V, 64'd0, 1'b0, 1'b1};
    vecs[6]  = '{MIN_V, 64'd1, MIN_V, 64'd0, 1'b0, 1'b0};
    vecs[7]  = '{MIN_V, 64'd2, 64'hC000_0000_0000_0000, 64'd0, 1'b0, 1'b0};
    vecs[8]  = '{64'd7, 64'd100, 64'd0, 64'd7, 1'b0, 1'b0};
    vecs[9]  = '{MAX_V, MIN_V, 64'd0, MAX_V, 1'b0, 1'b0};
    vecs[10] = '{MIN_V, MIN_V, 64'd1, 64'd0, 1'b0, 1'b0};
    vecs[11] = '{64'hFFFF_FFFF_FFFF_FFFF, MIN_V, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[12] = '{MIN_V, MAX_V, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[13] = '{MIN_V, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, MIN_V, 1'b1, 1'b0};
    vecs[14] = '{64'd0, 64'd5, 64'd0, 64'd0, 1'b0, 1'b0};
    vecs[15] = '{64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.quot, bus.rem} == '0 ? 64'd0 : 64'd1, 64'd0);
    chk("reset_flags", {60'd0, bus.busy, bus.done, bus.div0, bus.ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      do_op(vecs[i].a, vecs[i].b, q, r, d0, ov, lat, busy_cnt, busy_at_done);
      exp_lat = (vecs[i].d0 || vecs[i].ov) ? 1 : 65;
      chk($sformatf("vec%0d_quot", i), q, vecs[i].q);
      chk($sformatf("vec%0d_rem", i), r, vecs[i].r);
      chk($sformatf("vec%0d_flags", i), {62'd0, d0, ov}, {62'd0, vecs[i].d0, vecs[i].ov});
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat));
      chk($sformatf("vec%0d_busy_cycles", i), 64'(busy_cnt), 64'(exp_lat));
      chk($sformatf("vec%0d_busy_at_done", i), {63'd0, busy_at_done}, 64'd0);
    end

    // start pulsed mid-operation must be ignored; results hold during CALC
    prev_q = bus.quot;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 64'd1000;
    bus.b     = 64'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    ndone = 0;
    dcyc  = 0;
    q     = '0;
    r     = '0;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 10) begin
        chk("hold_quot_during_calc", bus.quot, prev_q);
        bus.start = 1'b1;
        bus.a     = 64'd9;
        bus.b     = 64'd2;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        ndone++;
        dcyc = cyc;
        q    = bus.quot;
        r    = bus.rem;
      end
    end
    chk("ignored_start_done_count", 64'(ndone), 64'd1);
    chk("ignored_start_latency", 64'(dcyc), 64'd65);
    chk("ignored_start_quot", q, 64'd333);
    chk("ignored_start_rem", r, 64'd1);

    // asynchronous reset mid-operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 64'd1000;
    bus.b     = 64'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_quot", bus.quot, 64'd0);
    chk("async_reset_rem", bus.rem, 64'd0);
    chk("async_reset_status", {60'd0, bus.busy, bus.done, bus.div0, bus.ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) bad = 1'b1;
    end
    chk("no_stale_done", {63'd0, bad}, 64'd0);
    do_op(64'd9, 64'd2, q, r, d0, ov, lat, busy_cnt, busy_at_done);
    chk("post_reset_quot", q, 64'd4);
    chk("post_reset_rem", r, 64'd1);
    chk("post_reset_latency", 64'(lat), 64'd65);

    // back-to-back random operations with start held high throughout
    begin
      logic [63:0] ca, cb, na, nb;
      rand_operand(ca);
      rand_operand(cb);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = ca;
      bus.b     = cb;
      @(posedge clk);
      #1;
      for (int i = 0; i < 500; i++) begin
        bus.a = {$urandom, $urandom};
        bus.b = {$urandom, $urandom};
        lat = 0;
        while (!bus.done && lat < 200) begin
          @(posedge clk);
          #1;
          lat++;
        end
        ref_div(ca, cb, eq, er, ed0, eov);
        exp_lat = (ed0 || eov) ? 1 : 65;
        chk($sformatf("rnd%0d_latency", i), 64'(lat), 64'(exp_lat));
        chk($sformatf("rnd%0d_quot", i), bus.quot, eq);
        chk($sformatf("rnd%0d_rem", i), bus.rem, er);
        chk($sformatf("rnd%0d_flags", i), {62'd0, bus.div0, bus.ovf}, {62'd0, ed0, eov});
        if (!ed0 && !eov) begin
          inv = $signed(bus.quot) * $signed(cb) + $signed(bus.rem);
          bad = (64'(inv) != ca) || !(mag(bus.rem) < mag(cb));
          chk($sformatf("rnd%0d_invariant", i), {63'd0, bad}, 64'd0);
        end
        if (i < 499) begin
          rand_operand(na);
          rand_operand(nb);
          ca    = na;
          cb    = nb;
          bus.a = ca;
          bus.b = cb;
          @(posedge clk);
          #1;
        end else begin
          bus.start = 1'b0;
        end
      end
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
